dsm_model: RTL and testbench

- Elastic sample buffer between an external delta-sigma modulator (DSM) sample stream (nominal 144 kHz strobe) and an internal DSM consumer.
- External samples are written into a circular buffer at save_index. The internal side consumes them in order at read_index.
- Everything runs in one clock domain. External and internal rates are expressed as enable strobes.
- Indices and fill status are exported for monitoring and rate control.

---
 rtl/dsm_pkg.sv | 15 +
 rtl/dsm_if.sv | 34 +++
 rtl/dsm_ring_mem.sv | 28 ++
 rtl/dsm_model.sv | 95 +++++++++
 tb/tb_dsm_model.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dsm_pkg.sv
// Shared types and default sizes for the DSM elastic sample buffer.
// Any module sized from these defaults agrees on sample width and index width.
package dsm_pkg;

  localparam int DSM_WIDTH = 4;
  localparam int DSM_DEPTH = 256;
  localparam int DSM_IDX_W = 8;

  typedef logic [DSM_WIDTH-1:0] dsm_sample_t;

  function automatic bit dsm_is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/dsm_if.sv
// Stream and monitor signals between the DSM buffer and its neighbours.
// The master side drives the strobes; the slave side is the buffer itself.
interface dsm_if
  import dsm_pkg::*;
#(
  parameter int WIDTH = DSM_WIDTH,
  parameter int IDX_W = DSM_IDX_W
);

  logic             ext_valid;
  logic [WIDTH-1:0] ext_bit;
  logic             int_read;
  logic [WIDTH-1:0] internal_bit;
  logic [IDX_W-1:0] save_index;
  logic [IDX_W-1:0] read_index;
  logic [IDX_W:0]   level;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output ext_valid, ext_bit, int_read,
    input  internal_bit, save_index, read_index, level,
    input  empty, full, overflow, underflow
  );

  modport slave (
    input  ext_valid, ext_bit, int_read,
    output internal_bit, save_index, read_index, level,
    output empty, full, overflow, underflow
  );

endinterface

// File: rtl/dsm_ring_mem.sv
// Register-array storage for the DSM buffer: clocked write, combinational read.
// Contents are deliberately not reset; validity is tracked by the fill level.
module dsm_ring_mem
  import dsm_pkg::*;
#(
  parameter int WIDTH = DSM_WIDTH,
  parameter int DEPTH = DSM_DEPTH,
  parameter int IDX_W = DSM_IDX_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dsm_model.sv
// Elastic buffer between the external DSM sample strobe and the internal consumer.
// Indices, fill level and sticky error flags live here; storage is in dsm_ring_mem.
module dsm_model
  import dsm_pkg::*;
#(
  parameter int WIDTH = DSM_WIDTH,
  parameter int DEPTH = DSM_DEPTH,
  parameter int IDX_W = DSM_IDX_W
) (
  input  logic clk,
  input  logic reset,
  dsm_if.slave bus
);

  if (!dsm_is_pow2(DEPTH) || (DEPTH != (1 << IDX_W))) begin : g_bad_depth
    $error("dsm_model: DEPTH must be a power of two equal to 2**IDX_W");
  end

  localparam logic [IDX_W:0]   LEVEL_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W:0]   LEVEL_ONE  = (IDX_W+1)'(1);

  logic [IDX_W-1:0] save_q;
  logic [IDX_W-1:0] read_q;
  logic [IDX_W:0]   level_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] held_q;
  logic [WIDTH-1:0] head;
  logic             empty;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LEVEL_FULL);

  // A full buffer still takes a write when a read frees a slot on the same edge.
  assign rd_ok = bus.int_read && !empty;
  assign wr_ok = bus.ext_valid && (!full || rd_ok);

  dsm_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok && !reset),
    .wr_addr (save_q),
    .wr_data (bus.ext_bit),
    .rd_addr (read_q),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      save_q      <= '0;
      read_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      held_q      <= '0;
    end else begin
      if (wr_ok) begin
        save_q <= save_q + IDX_ONE;
      end else if (bus.ext_valid) begin
        overflow_q <= 1'b1;
      end

      if (rd_ok) begin
        read_q <= read_q + IDX_ONE;
        held_q <= head;
      end else if (bus.int_read) begin
        underflow_q <= 1'b1;
      end

      if (wr_ok && !rd_ok) begin
        level_q <= level_q + LEVEL_ONE;
      end else if (rd_ok && !wr_ok) begin
        level_q <= level_q - LEVEL_ONE;
      end
    end
  end

  // Once drained, keep presenting the last consumed sample instead of stale memory.
  assign bus.internal_bit = empty ? held_q : head;
  assign bus.save_index   = save_q;
  assign bus.read_index   = read_q;
  assign bus.level        = level_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_dsm_model.sv
// Directed bench for dsm_model: reset, fill, drain, underflow, overflow and wrap.
module tb_dsm_model;
  import dsm_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  logic [3:0] exp_data [256];
  logic [3:0] q [$];

  dsm_if #(.WIDTH(4), .IDX_W(8)) bus ();

  dsm_model #(.WIDTH(4), .DEPTH(256), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ext_valid = 1'b1;
    bus.ext_bit   = 4'hF;
    bus.int_read  = 1'b0;
    step();
    step();
    chk("rst_save",  32'(bus.save_index), 0);
    chk("rst_read",  32'(bus.read_index), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_ibit",  32'(bus.internal_bit), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ovf",   32'(bus.overflow), 0);
    chk("rst_unf",   32'(bus.underflow), 0);

    // Fill with E, D, C
    reset = 1'b0;
    bus.ext_bit = 4'hE;
    step();
    chk("fill1_save", 32'(bus.save_index), 1);
    chk("fill1_ibit", 32'(bus.internal_bit), 32'hE);
    bus.ext_bit = 4'hD;
    step();
    chk("fill2_save", 32'(bus.save_index), 2);
    chk("fill2_ibit", 32'(bus.internal_bit), 32'hE);
    bus.ext_bit = 4'hC;
    step();
    chk("fill3_save",  32'(bus.save_index), 3);
    chk("fill3_level", 32'(bus.level), 3);
    chk("fill3_ibit",  32'(bus.internal_bit), 32'hE);
    chk("fill3_read",  32'(bus.read_index), 0);

    // Drain
    bus.ext_valid = 1'b0;
    bus.int_read  = 1'b1;
    step();
    chk("drain1_read", 32'(bus.read_index), 1);
    chk("drain1_ibit", 32'(bus.internal_bit), 32'hD);
    step();
    chk("drain2_read", 32'(bus.read_index), 2);
    chk("drain2_ibit", 32'(bus.internal_bit), 32'hC);
    step();
    chk("drain3_read",  32'(bus.read_index), 3);
    chk("drain3_empty", 32'(bus.empty), 1);
    chk("drain3_ibit",  32'(bus.internal_bit), 32'hC);
    chk("drain3_unf",   32'(bus.underflow), 0);

    // Read on empty with a simultaneous write
    bus.ext_valid = 1'b1;
    bus.ext_bit   = 4'h5;
    step();
    chk("unf_flag",  32'(bus.underflow), 1);
    chk("unf_read",  32'(bus.read_index), 3);
    chk("unf_level", 32'(bus.level), 1);
    chk("unf_ibit",  32'(bus.internal_bit), 32'h5);
    chk("unf_save",  32'(bus.save_index), 4);

    // Reset mid-operation with both strobes active
    reset = 1'b1;
    bus.ext_bit = 4'h7;
    step();
    reset = 1'b0;
    bus.ext_valid = 1'b0;
    bus.int_read  = 1'b0;
    chk("mrst_save",  32'(bus.save_index), 0);
    chk("mrst_read",  32'(bus.read_index), 0);
    chk("mrst_level", 32'(bus.level), 0);
    chk("mrst_unf",   32'(bus.underflow), 0);
    chk("mrst_ibit",  32'(bus.internal_bit), 0);

    // Fill to full
    for (int i = 0; i < 256; i++) exp_data[i] = 4'((i * 7 + 3) & 15);
    bus.ext_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.ext_bit = exp_data[i];
      q.push_back(exp_data[i]);
      step();
      if (i == 254) begin
        chk("f255_level", 32'(bus.level), 255);
        chk("f255_full",  32'(bus.full), 0);
        chk("f255_save",  32'(bus.save_index), 255);
      end
    end
    chk("full_flag",  32'(bus.full), 1);
    chk("full_level", 32'(bus.level), 256);
    chk("full_save",  32'(bus.save_index), 0);
    chk("full_ovf",   32'(bus.overflow), 0);
    chk("full_ibit",  32'(bus.internal_bit), 32'(exp_data[0]));

    // 257th write is dropped
    bus.ext_bit = 4'hA;
    step();
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_level", 32'(bus.level), 256);
    chk("ovf_save",  32'(bus.save_index), 0);
    chk("ovf_ibit",  32'(bus.internal_bit), 32'(exp_data[0]));

    // Write plus read while full
    bus.ext_bit  = 4'h9;
    bus.int_read = 1'b1;
    void'(q.pop_front());
    q.push_back(4'h9);
    step();
    chk("wr_rd_level", 32'(bus.level), 256);
    chk("wr_rd_save",  32'(bus.save_index), 1);
    chk("wr_rd_read",  32'(bus.read_index), 1);
    chk("wr_rd_ibit",  32'(bus.internal_bit), 32'(exp_data[1]));
    chk("wr_rd_unf",   32'(bus.underflow), 0);

    // Drain everything, crossing the index wrap
    bus.ext_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("wrap_order", 32'(bus.internal_bit), 32'(q[0]));
      void'(q.pop_front());
      step();
      if (i == 254) begin
        chk("wrap_read", 32'(bus.read_index), 0);
        chk("wrap_ibit", 32'(bus.internal_bit), 32'h9);
      end
    end
    bus.int_read = 1'b0;
    chk("end_read",  32'(bus.read_index), 1);
    chk("end_empty", 32'(bus.empty), 1);
    chk("end_level", 32'(bus.level), 0);
    chk("end_ibit",  32'(bus.internal_bit), 32'h9);
    chk("end_ovf",   32'(bus.overflow), 1);
    chk("end_unf",   32'(bus.underflow), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
